// File: rtl/dram_client.sv
// Initiator-side controller for a single-cycle-write, registered-read dual-port RAM.
// Optional write acknowledgements are enabled by defining DRAM_CLIENT_WACK_EN.
module dram_client #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_write,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr_write,
  output logic [ADDR_WIDTH-1:0] mem_addr_read,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int OW = $clog2(RESP_DEPTH + 1);
  localparam int CW = OW + 1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(RESP_DEPTH - 1)) return '0;
    else return p + PW'(1);
  endfunction

  function automatic logic [OW-1:0] occ_upd(input logic [OW-1:0] o,
                                            input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return o + OW'(1);
      2'b01:   return o - OW'(1);
      default: return o;
    endcase
  endfunction

  logic            accept;
  logic            issue;
  logic            vld_p1;
  logic            is_wack_p1;
  logic            push;
  logic            pop;
  logic [DATA_WIDTH-1:0] push_data;
  logic [OW-1:0]   occ;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   used;
  logic [DATA_WIDTH-1:0] fifo_data [RESP_DEPTH];
  logic            fifo_wack [RESP_DEPTH];

  // Stage 0: request acceptance and combinational RAM port drive
  // Every in-flight operation already owns a FIFO slot, so occ can never overflow.
  assign used      = CW'(occ) + CW'(vld_p1);
  assign req_ready = !rst && (used < CW'(RESP_DEPTH));
  assign accept    = req_valid & req_ready;

  assign mem_we         = accept & req_we;
  assign mem_addr_write = req_addr;
  assign mem_addr_read  = req_addr;
  assign mem_data_in    = req_wdata;

`ifdef DRAM_CLIENT_WACK_EN
  assign issue = accept;
`else
  assign issue = accept & ~req_we;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= issue;
  end

`ifdef DRAM_CLIENT_WACK_EN
  always_ff @(posedge clk) begin
    is_wack_p1 <= req_we;
  end
`else
  assign is_wack_p1 = 1'b0;
`endif

  // Stage 1: RAM read data is valid now and lands in the response FIFO
  assign push      = vld_p1;
  assign pop       = resp_valid & resp_ready;
  assign push_data = is_wack_p1 ? '0 : mem_data_out;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_wack[wr_ptr] <= is_wack_p1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      occ <= occ_upd(occ, push, pop);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Stage 2: FIFO head presented on the response channel
  assign resp_valid = (occ != '0);
  assign resp_data  = resp_valid ? fifo_data[rd_ptr] : '0;

`ifdef DRAM_CLIENT_WACK_EN
  assign resp_write = resp_valid & fifo_wack[rd_ptr];
`else
  assign resp_write = 1'b0;
`endif

endmodule

// File: tb/tb_dram_client.sv
// Directed self-checking bench for dram_client with a behavioural registered-read RAM.
module tb_dram_client;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_write;
  logic        mem_we;
  logic [7:0]  mem_addr_write;
  logic [7:0]  mem_addr_read;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [256];
  logic [31:0] rd_q;

  dram_client #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RESP_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_write(resp_write),
    .mem_we(mem_we), .mem_addr_write(mem_addr_write), .mem_addr_read(mem_addr_read),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr_write] <= mem_data_in;
    rd_q <= mem[mem_addr_read];
  end
  assign mem_data_out = rd_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [7:0] a, input logic [31:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
    rst = 1'b1;
    resp_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h33, 32'h12345678);

    // reset state with a pending write request
    repeat (2) @(negedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_write", 32'(resp_write), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    chk("rel_resp_valid", 32'(resp_valid), 32'd0);

    // preload addresses 0..7 with 0x100+i
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 8'(i), 32'h100 + 32'(i));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("pre_drained", 32'(resp_valid), 32'd0);

    // write then read of the same address
    @(negedge clk);
    drive(1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
    #1;
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_addr", 32'(mem_addr_write), 32'h10);
    chk("wr_mem_data", mem_data_in, 32'hDEADBEEF);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h10, 32'h0);
    #1;
    chk("rd_mem_we", 32'(mem_we), 32'd0);
    chk("rd_mem_addr", 32'(mem_addr_read), 32'h10);
    chk("rd_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    #1;
`ifdef DRAM_CLIENT_WACK_EN
    chk("wr_ack_valid", 32'(resp_valid), 32'd1);
    chk("wr_ack_write", 32'(resp_write), 32'd1);
    chk("wr_ack_data", resp_data, 32'd0);
`else
    chk("wr_no_ack", 32'(resp_valid), 32'd0);
`endif
    @(negedge clk); #1;
    chk("wr_rd_valid", 32'(resp_valid), 32'd1);
    chk("wr_rd_data", resp_data, 32'hDEADBEEF);
    chk("wr_rd_write", 32'(resp_write), 32'd0);
    @(negedge clk); #1;
    chk("wr_rd_empty", 32'(resp_valid), 32'd0);

    // back-to-back reads at full throughput
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 8) drive(1'b1, 1'b0, 8'(c), 32'h0);
      else       drive(1'b0, 1'b0, 8'h00, 32'h0);
      #1;
      if (c < 8) chk("tp_req_ready", 32'(req_ready), 32'd1);
      if (c >= 2) begin
        chk("tp_resp_valid", 32'(resp_valid), 32'd1);
        chk("tp_resp_data", resp_data, 32'h100 + 32'(c - 2));
      end
    end
    @(negedge clk); #1;
    chk("tp_empty", 32'(resp_valid), 32'd0);

    // backpressure: only four reads fit
    resp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 8'(c), 32'h0);
      #1;
      chk("bp_req_ready", 32'(req_ready), (c < 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    #1;
    chk("bp_full_ready", 32'(req_ready), 32'd0);
    chk("bp_head_valid", 32'(resp_valid), 32'd1);
    chk("bp_head_data", resp_data, 32'h100);
    @(negedge clk); #1;
    chk("bp_hold_data", resp_data, 32'h100);
    resp_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); #1;
      chk("bp_drain_valid", 32'(resp_valid), 32'd1);
      chk("bp_drain_data", resp_data, 32'h100 + 32'(k));
    end
    @(negedge clk); #1;
    chk("bp_drain_empty", 32'(resp_valid), 32'd0);

    // reset with two buffered and one in-flight read
    resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 8'(c), 32'h0);
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 8'h20, 32'h00000BAD);
    #1;
    chk("mf_pre_valid", 32'(resp_valid), 32'd1);
    chk("mf_pre_ready", 32'(req_ready), 32'd1);
    rst = 1'b1;
    #1;
    chk("mf_rst_valid", 32'(resp_valid), 32'd0);
    chk("mf_rst_ready", 32'(req_ready), 32'd0);
    chk("mf_rst_mem_we", 32'(mem_we), 32'd0);
    chk("mf_rst_data", resp_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    resp_ready = 1'b1;
    #1;
    chk("mf_rel_valid", 32'(resp_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("mf_no_stale", 32'(resp_valid), 32'd0);
      chk("mf_ready", 32'(req_ready), 32'd1);
    end

    // alternating write/read of address 5
    @(negedge clk);
    drive(1'b1, 1'b1, 8'h05, 32'h1);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h05, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    #1;
`ifdef DRAM_CLIENT_WACK_EN
    chk("alt_ack_valid", 32'(resp_valid), 32'd1);
    chk("alt_ack_write", 32'(resp_write), 32'd1);
    chk("alt_ack_data", resp_data, 32'd0);
`else
    chk("alt_no_ack", 32'(resp_valid), 32'd0);
    chk("alt_no_ack_write", 32'(resp_write), 32'd0);
`endif
    @(negedge clk); #1;
    chk("alt_rd_valid", 32'(resp_valid), 32'd1);
    chk("alt_rd_write", 32'(resp_write), 32'd0);
    chk("alt_rd_data", resp_data, 32'h1);
    @(negedge clk); #1;
    chk("alt_empty", 32'(resp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
